load_store_unit: RTL and testbench

//  Memory stage of the RV32I core, directly downstream of the ALU. Takes the ALU result as the effective

---
 rtl/load_store_unit_pkg.sv | 41 ++++
 rtl/lsu_align.sv | 70 +++++++
 rtl/load_store_unit.sv | 152 +++++++++++++++
 tb/tb_load_store_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types for the RV32I memory stage: memory op encoding, LSU FSM states, fault causes
// and the funct3 width codes used by loads and stores.
package load_store_unit_pkg;

  typedef struct packed {
    logic       is_store;
    logic [2:0] funct3;
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    NONE       = 2'd0,
    MISALIGNED = 2'd1,
    ILLEGAL    = 2'd2,
    TIMEOUT    = 2'd3
  } lsu_fault_t;

  localparam logic [2:0] FUNCT3_B  = 3'd0;
  localparam logic [2:0] FUNCT3_H  = 3'd1;
  localparam logic [2:0] FUNCT3_W  = 3'd2;
  localparam logic [2:0] FUNCT3_BU = 3'd4;
  localparam logic [2:0] FUNCT3_HU = 3'd5;

  // Whether funct3 names a real RV32I load or store for the given direction.
  function automatic logic op_is_legal(input mem_op_t op);
    if (op.is_store) begin
      op_is_legal = (op.funct3 == FUNCT3_B) || (op.funct3 == FUNCT3_H) ||
                    (op.funct3 == FUNCT3_W);
    end else begin
      op_is_legal = (op.funct3 == FUNCT3_B)  || (op.funct3 == FUNCT3_H) ||
                    (op.funct3 == FUNCT3_W)  || (op.funct3 == FUNCT3_BU) ||
                    (op.funct3 == FUNCT3_HU);
    end
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU: request legality/alignment check, store byte-enable and
// lane replication, and load lane extraction with sign/zero extension.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  mem_op_t     req_op,
  input  logic [1:0]  req_off,
  input  logic [31:0] req_data,
  output lsu_fault_t  req_cause,
  output logic [3:0]  req_be,
  output logic [31:0] req_wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_value
);

  logic        misaligned;
  logic [31:0] lane;

  always_comb begin
    misaligned = 1'b0;
    case (req_op.funct3[1:0])
      2'b01:   misaligned = req_off[0];
      2'b10:   misaligned = (req_off != 2'b00);
      default: misaligned = 1'b0;
    endcase
    // Illegal encodings are reported ahead of misalignment.
    req_cause = NONE;
    if (!op_is_legal(req_op)) begin
      req_cause = ILLEGAL;
    end else if (misaligned) begin
      req_cause = MISALIGNED;
    end
  end

  always_comb begin
    req_be    = 4'b1111;
    req_wdata = 32'h0000_0000;
    if (req_op.is_store) begin
      case (req_op.funct3)
        FUNCT3_B: begin
          req_be    = 4'b0001 << req_off;
          req_wdata = {4{req_data[7:0]}};
        end
        FUNCT3_H: begin
          req_be    = 4'b0011 << {req_off[1], 1'b0};
          req_wdata = {2{req_data[15:0]}};
        end
        default: begin
          req_be    = 4'b1111;
          req_wdata = req_data;
        end
      endcase
    end
  end

  always_comb begin
    lane     = rdata >> {ld_off, 3'b000};
    ld_value = lane;
    case (ld_funct3)
      FUNCT3_B:  ld_value = {{24{lane[7]}}, lane[7:0]};
      FUNCT3_H:  ld_value = {{16{lane[15]}}, lane[15:0]};
      FUNCT3_BU: ld_value = {24'h000000, lane[7:0]};
      FUNCT3_HU: ld_value = {16'h0000, lane[15:0]};
      default:   ld_value = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: one req/ack data-memory transaction per load/store, PC stall while busy,
// and misaligned / illegal / bus-timeout fault reporting.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [1:0]  dbg_state
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_t  state_q, state_d;
  mem_op_t     req_op, op_q;
  lsu_fault_t  req_cause, cause_q, cause_out;
  logic [31:0] addr_q, wdata_q, load_q;
  logic [3:0]  be_q;
  logic [7:0]  cnt_q;
  logic [3:0]  req_be;
  logic [31:0] req_wdata, ld_value;
  logic        accept, capture, timeout_hit;

  assign req_op = mem_op_t'(mem_op);

  lsu_align u_align (
    .req_op    (req_op),
    .req_off   (addr[1:0]),
    .req_data  (store_data),
    .req_cause (req_cause),
    .req_be    (req_be),
    .req_wdata (req_wdata),
    .ld_funct3 (op_q.funct3),
    .ld_off    (addr_q[1:0]),
    .rdata     (dmem_rdata),
    .ld_value  (ld_value)
  );

  // Memory handshake: dmem_req is raised on entry to WAIT and held, with every dmem_* field
  // driven from capture registers, until the cycle dmem_ack=1 (transfer happens on that edge).
  // dmem_ack in any other state is ignored. A timeout withdraws the request without a transfer.
  always_comb begin
    state_d     = state_q;
    busy        = 1'b0;
    done        = 1'b0;
    fault       = 1'b0;
    cause_out   = NONE;
    accept      = 1'b0;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_cause != NONE) begin
            fault     = 1'b1;
            cause_out = req_cause;
          end else begin
            accept  = 1'b1;
            busy    = 1'b1;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (dmem_ack) begin
          capture = !op_q.is_store;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_hit = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (cause_q == TIMEOUT) begin
          fault     = 1'b1;
          cause_out = TIMEOUT;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q    <= '0;
      addr_q  <= 32'h0000_0000;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0000_0000;
      cnt_q   <= 8'd0;
      cause_q <= NONE;
      load_q  <= 32'h0000_0000;
    end else begin
      if (accept) begin
        op_q    <= req_op;
        addr_q  <= addr;
        be_q    <= req_be;
        wdata_q <= req_wdata;
        cnt_q   <= 8'd0;
        cause_q <= NONE;
      end
      if (state_q == WAIT && !dmem_ack && !timeout_hit) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (timeout_hit) begin
        cause_q <= TIMEOUT;
      end
      if (capture) begin
        load_q <= ld_value;
      end
    end
  end

  // Outside WAIT the bus is parked at zero so nothing stale is presented to memory.
  assign dmem_req    = (state_q == WAIT);
  assign dmem_we     = dmem_req & op_q.is_store;
  assign dmem_addr   = dmem_req ? {addr_q[31:2], 2'b00} : 32'h0000_0000;
  assign dmem_be     = dmem_req ? be_q : 4'b0000;
  assign dmem_wdata  = dmem_req ? wdata_q : 32'h0000_0000;
  assign load_data   = load_q;
  assign fault_cause = cause_out;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a short bus timeout so the timeout path is reachable.
module tb_load_store_unit;

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0010;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1010;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [3:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic        fault;
  logic [1:0]  fault_cause;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [1:0]  dbg_state;

  int checks = 0;
  int passed = 0;

  // results of the most recent run_access
  int          busy_n, done_n, req_n;
  logic [31:0] o_addr, o_wdata;
  logic [3:0]  o_be;
  logic        o_we, o_fault;
  logic [1:0]  o_cause;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .mem_op      (mem_op),
    .addr        (addr),
    .store_data  (store_data),
    .busy        (busy),
    .done        (done),
    .load_data   (load_data),
    .fault       (fault),
    .fault_cause (fault_cause),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .dmem_ack    (dmem_ack),
    .dmem_rdata  (dmem_rdata),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // driver: present a request at a negedge and let combinational outputs settle
  task automatic drive_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid  = 1'b1;
    mem_op     = op;
    addr       = a;
    store_data = d;
    #1;
  endtask

  // driver: run one access for 20 cycles; memory acks on WAIT cycle index ack_wait (-1 = never)
  task automatic run_access(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] rd, input int ack_wait);
    busy_n = 0; done_n = 0; req_n = 0;
    o_addr = '0; o_wdata = '0; o_be = '0; o_we = 1'b0; o_fault = 1'b0; o_cause = 2'd0;
    dmem_rdata = rd;
    dmem_ack   = 1'b0;
    drive_req(op, a, d);
    for (int c = 0; c < 20; c++) begin
      if (c != 0) #1;
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        o_fault = fault;
        o_cause = fault_cause;
      end
      if (dmem_req) begin
        if (req_n == 0) begin
          o_addr = dmem_addr; o_wdata = dmem_wdata; o_be = dmem_be; o_we = dmem_we;
        end
        if (req_n == ack_wait) dmem_ack = 1'b1;
        req_n++;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      dmem_ack  = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else passed++;
    checks++; if (fault !== 1'b0 || fault_cause !== 2'd0) $display("FAIL rst_fault: got %b/%0d want 0/0", fault, fault_cause); else passed++;
    checks++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || dmem_be !== 4'h0) $display("FAIL rst_bus: got req=%b we=%b be=%h want 0", dmem_req, dmem_we, dmem_be); else passed++;
    checks++; if (dmem_addr !== 32'h0 || dmem_wdata !== 32'h0 || load_data !== 32'h0) $display("FAIL rst_data: got a=%h w=%h ld=%h want 0", dmem_addr, dmem_wdata, load_data); else passed++;
    checks++; if (dbg_state !== 2'd0) $display("FAIL rst_state: got %0d want 0", dbg_state); else passed++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_store_word();
    run_access(OP_SW, 32'h100, 32'hDEADBEEF, 32'h0, 1);
    checks++; if (o_addr !== 32'h100) $display("FAIL sw_addr: got %h want 00000100", o_addr); else passed++;
    checks++; if (o_be !== 4'b1111 || o_we !== 1'b1) $display("FAIL sw_be_we: got %b/%b want 1111/1", o_be, o_we); else passed++;
    checks++; if (o_wdata !== 32'hDEADBEEF) $display("FAIL sw_wdata: got %h want deadbeef", o_wdata); else passed++;
    checks++; if (busy_n !== 3) $display("FAIL sw_busy_cycles: got %0d want 3", busy_n); else passed++;
    checks++; if (done_n !== 1 || o_fault !== 1'b0) $display("FAIL sw_done: got %0d pulses fault=%b want 1/0", done_n, o_fault); else passed++;
    checks++; if (req_n !== 2) $display("FAIL sw_req_cycles: got %0d want 2", req_n); else passed++;
    run_access(OP_SW, 32'h104, 32'h01020304, 32'h0, 0);
    checks++; if (busy_n !== 2) $display("FAIL sw_min_latency: got %0d busy want 2", busy_n); else passed++;
  endtask

  task automatic test_loads();
    run_access(OP_LB, 32'h103, 32'h0, 32'h80FF1234, 0);
    checks++; if (load_data !== 32'hFFFFFF80) $display("FAIL lb: got %h want ffffff80", load_data); else passed++;
    checks++; if (o_we !== 1'b0 || o_be !== 4'b1111 || o_addr !== 32'h100) $display("FAIL lb_bus: got we=%b be=%b a=%h want 0/1111/100", o_we, o_be, o_addr); else passed++;
    run_access(OP_LBU, 32'h103, 32'h0, 32'h80FF1234, 0);
    checks++; if (load_data !== 32'h00000080) $display("FAIL lbu: got %h want 00000080", load_data); else passed++;
    run_access(OP_LH, 32'h102, 32'h0, 32'h80FF1234, 0);
    checks++; if (load_data !== 32'hFFFF80FF) $display("FAIL lh: got %h want ffff80ff", load_data); else passed++;
    run_access(OP_LHU, 32'h102, 32'h0, 32'h80FF1234, 0);
    checks++; if (load_data !== 32'h000080FF) $display("FAIL lhu: got %h want 000080ff", load_data); else passed++;
    run_access(OP_LB, 32'h101, 32'h0, 32'h80FF1234, 2);
    checks++; if (load_data !== 32'h00000012) $display("FAIL lb_pos: got %h want 00000012", load_data); else passed++;
    run_access(OP_LW, 32'h100, 32'h0, 32'h80FF1234, 0);
    checks++; if (load_data !== 32'h80FF1234) $display("FAIL lw: got %h want 80ff1234", load_data); else passed++;
  endtask

  task automatic test_sub_stores();
    run_access(OP_SH, 32'h102, 32'h0000ABCD, 32'h11111111, 0);
    checks++; if (o_be !== 4'b1100 || o_addr !== 32'h100) $display("FAIL sh_be: got %b a=%h want 1100/100", o_be, o_addr); else passed++;
    checks++; if (o_wdata !== 32'hABCDABCD) $display("FAIL sh_wdata: got %h want abcdabcd", o_wdata); else passed++;
    run_access(OP_SB, 32'h101, 32'h0000005A, 32'h11111111, 0);
    checks++; if (o_be !== 4'b0010 || o_we !== 1'b1) $display("FAIL sb_be: got %b we=%b want 0010/1", o_be, o_we); else passed++;
    checks++; if (o_wdata !== 32'h5A5A5A5A) $display("FAIL sb_wdata: got %h want 5a5a5a5a", o_wdata); else passed++;
    checks++; if (load_data !== 32'h80FF1234) $display("FAIL store_keeps_load: got %h want 80ff1234", load_data); else passed++;
  endtask

  task automatic test_faults();
    drive_req(OP_LW, 32'h102, 32'h0);
    checks++; if (fault !== 1'b1 || fault_cause !== 2'd1) $display("FAIL lw_misaligned: got %b/%0d want 1/1", fault, fault_cause); else passed++;
    checks++; if (dmem_req !== 1'b0 || busy !== 1'b0) $display("FAIL misaligned_no_req: got req=%b busy=%b want 0/0", dmem_req, busy); else passed++;
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk); #1;
    checks++; if (dbg_state !== 2'd0 || dmem_req !== 1'b0 || fault !== 1'b0) $display("FAIL misaligned_stay_idle: got st=%0d req=%b f=%b want 0/0/0", dbg_state, dmem_req, fault); else passed++;
    drive_req(4'b0011, 32'h100, 32'h0);
    checks++; if (fault !== 1'b1 || fault_cause !== 2'd2 || busy !== 1'b0) $display("FAIL load_f3_3: got %b/%0d busy=%b want 1/2/0", fault, fault_cause, busy); else passed++;
    drive_req(4'b1100, 32'h100, 32'h0);
    checks++; if (fault !== 1'b1 || fault_cause !== 2'd2) $display("FAIL store_f3_4: got %b/%0d want 1/2", fault, fault_cause); else passed++;
    drive_req(4'b0110, 32'h101, 32'h0);
    checks++; if (fault !== 1'b1 || fault_cause !== 2'd2) $display("FAIL illegal_over_misaligned: got %b/%0d want 1/2", fault, fault_cause); else passed++;
    drive_req(OP_SH, 32'h101, 32'h0);
    checks++; if (fault !== 1'b1 || fault_cause !== 2'd1) $display("FAIL sh_misaligned: got %b/%0d want 1/1", fault, fault_cause); else passed++;
    drive_req(OP_LHU, 32'h102, 32'h0);
    checks++; if (fault !== 1'b0 || busy !== 1'b1) $display("FAIL lhu_aligned_ok: got f=%b busy=%b want 0/1", fault, busy); else passed++;
    @(posedge clk); #1; req_valid = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h80FF1234;
    @(posedge clk); #1; dmem_ack = 1'b0;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_timeout();
    run_access(OP_LW, 32'h200, 32'h0, 32'h55555555, -1);
    checks++; if (req_n !== 4) $display("FAIL to_req_cycles: got %0d want 4", req_n); else passed++;
    checks++; if (done_n !== 1 || o_fault !== 1'b1 || o_cause !== 2'd3) $display("FAIL to_done_fault: got %0d/%b/%0d want 1/1/3", done_n, o_fault, o_cause); else passed++;
    checks++; if (busy_n !== 5) $display("FAIL to_busy_cycles: got %0d want 5", busy_n); else passed++;
    checks++; if (load_data !== 32'h000080FF) $display("FAIL to_load_kept: got %h want 000080ff", load_data); else passed++;
    run_access(OP_LW, 32'h200, 32'h0, 32'h24681357, 3);
    checks++; if (o_fault !== 1'b0 || load_data !== 32'h24681357) $display("FAIL ack_beats_timeout: got f=%b ld=%h want 0/24681357", o_fault, load_data); else passed++;
  endtask

  task automatic test_ack_outside_wait();
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = 32'h99999999;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (dbg_state !== 2'd0 || done !== 1'b0 || load_data !== 32'h24681357) $display("FAIL stray_ack: got st=%0d done=%b ld=%h want 0/0/24681357", dbg_state, done, load_data); else passed++;
    dmem_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    int bn, dn;
    bn = 0; dn = 0;
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
    drive_req(OP_LW, 32'h104, 32'h0);
    for (int c = 0; c < 6; c++) begin
      if (c != 0) #1;
      if (busy) bn++;
      if (done) dn++;
      @(posedge clk); #1;
      if (c == 5) begin req_valid = 1'b0; dmem_ack = 1'b0; end
      @(negedge clk);
    end
    checks++; if (dn !== 2 || bn !== 4) $display("FAIL b2b_counts: got done=%0d busy=%0d want 2/4", dn, bn); else passed++;
    #1;
    checks++; if (dbg_state !== 2'd0 || busy !== 1'b0 || load_data !== 32'hCAFEF00D) $display("FAIL b2b_end: got st=%0d busy=%b ld=%h want 0/0/cafef00d", dbg_state, busy, load_data); else passed++;
  endtask

  task automatic test_reset_mid_wait();
    int dn;
    dn = 0;
    drive_req(OP_LW, 32'h300, 32'h0);
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk); #1;
    checks++; if (dmem_req !== 1'b1) $display("FAIL rmw_in_wait: got req=%b want 1", dmem_req); else passed++;
    reset = 1'b0;
    #1;
    checks++; if (dmem_req !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0) $display("FAIL rmw_drop: got req=%b busy=%b st=%0d want 0/0/0", dmem_req, busy, dbg_state); else passed++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) dn++;
    end
    reset = 1'b1;
    #1;
    if (done) dn++;
    checks++; if (dn !== 0 || load_data !== 32'h0) $display("FAIL rmw_no_done: got %0d pulses ld=%h want 0/0", dn, load_data); else passed++;
    run_access(OP_LW, 32'h300, 32'h0, 32'h12345678, 0);
    checks++; if (done_n !== 1 || load_data !== 32'h12345678 || o_addr !== 32'h300) $display("FAIL rmw_fresh_lw: got %0d/%h/%h want 1/12345678/300", done_n, load_data, o_addr); else passed++;
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; mem_op = 4'h0; addr = 32'h0; store_data = 32'h0;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    test_reset();
    test_store_word();
    test_loads();
    test_sub_stores();
    test_faults();
    test_timeout();
    test_ack_outside_wait();
    test_back_to_back();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
